// File: rtl/turf_udp_port_demux.sv
// Receive-side UDP dispatcher: steers each datagram's header and payload to the
// service output whose port number matches its destination, draining unknown ports.
module turf_udp_port_demux #(
    parameter int unsigned             NUM_PORTS = 4,
    parameter logic [NUM_PORTS*16-1:0] PORT_LIST = {16'd21618, 16'd21603, 16'd21600, 16'd21347}
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [63:0]             s_udphdr_tdata,
    input  logic [15:0]             s_udphdr_tdest,
    input  logic                    s_udphdr_tvalid,
    output logic                    s_udphdr_tready,
    input  logic [63:0]             s_udpdata_tdata,
    input  logic [7:0]              s_udpdata_tkeep,
    input  logic                    s_udpdata_tlast,
    input  logic                    s_udpdata_tvalid,
    output logic                    s_udpdata_tready,
    output logic [64*NUM_PORTS-1:0] m_hdr_tdata,
    output logic [NUM_PORTS-1:0]    m_hdr_tvalid,
    input  logic [NUM_PORTS-1:0]    m_hdr_tready,
    output logic [64*NUM_PORTS-1:0] m_data_tdata,
    output logic [8*NUM_PORTS-1:0]  m_data_tkeep,
    output logic [NUM_PORTS-1:0]    m_data_tlast,
    output logic [NUM_PORTS-1:0]    m_data_tvalid,
    input  logic [NUM_PORTS-1:0]    m_data_tready,
    output logic [31:0]             drop_count
);

    localparam int unsigned HDR_W  = 64;
    localparam int unsigned PORT_W = 16;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned SEL_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_DROP
    } state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [HDR_W-1:0]   hdr_q, hdr_d;
    logic [CNT_W-1:0]   drop_q, drop_d;
    logic               hdr_rdy_q, hdr_rdy_d;
    logic               hit;
    logic [SEL_W-1:0]   hit_idx;

    // Parallel port match; scanning downward leaves the lowest matching index.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
            if (s_udphdr_tdest == PORT_LIST[PORT_W*i +: PORT_W]) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            hdr_q     <= '0;
            drop_q    <= '0;
            hdr_rdy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            hdr_q     <= hdr_d;
            drop_q    <= drop_d;
            hdr_rdy_q <= hdr_rdy_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        sel_d            = sel_q;
        hdr_d            = hdr_q;
        drop_d           = drop_q;
        s_udpdata_tready = 1'b0;
        m_hdr_tvalid     = '0;
        m_data_tvalid    = '0;

        case (state_q)
            ST_IDLE: begin
                if (s_udphdr_tvalid && hdr_rdy_q) begin
                    hdr_d = s_udphdr_tdata;
                    if (hit) begin
                        sel_d   = hit_idx;
                        state_d = ST_HDR;
                    end else begin
                        state_d = ST_DROP;
                        if (drop_q != '1) begin
                            drop_d = drop_q + CNT_W'(1);
                        end
                    end
                end
            end
            ST_HDR: begin
                m_hdr_tvalid[sel_q] = 1'b1;
                if (m_hdr_tready[sel_q]) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                m_data_tvalid[sel_q] = s_udpdata_tvalid;
                s_udpdata_tready     = m_data_tready[sel_q];
                if (s_udpdata_tvalid && m_data_tready[sel_q] && s_udpdata_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                s_udpdata_tready = 1'b1;
                if (s_udpdata_tvalid && s_udpdata_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        hdr_rdy_d = (state_d == ST_IDLE);
    end

    // Payload fields fan out to every lane; only the selected lane's tvalid qualifies them.
    assign m_hdr_tdata     = {NUM_PORTS{hdr_q}};
    assign m_data_tdata    = {NUM_PORTS{s_udpdata_tdata}};
    assign m_data_tkeep    = {NUM_PORTS{s_udpdata_tkeep}};
    assign m_data_tlast    = {NUM_PORTS{s_udpdata_tlast}};
    assign s_udphdr_tready = hdr_rdy_q;
    assign drop_count      = drop_q;

endmodule

// File: tb/tb_turf_udp_port_demux.sv
// Bench for turf_udp_port_demux: datagram-level reference model with a per-cycle
// compare process, directed scenarios and randomized backpressure traffic.
module tb_turf_udp_port_demux;

    localparam int unsigned NP = 4;
    localparam int unsigned BOUND = 200;
    // Entry i sits at [16*i +: 16]: lane0=21618, lane1=21603, lane2=21600, lane3=21347.
    localparam logic [NP*16-1:0] PLIST     = {16'd21347, 16'd21600, 16'd21603, 16'd21618};
    localparam logic [NP*16-1:0] PLIST_DUP = {16'd21347, 16'd21600, 16'd21600, 16'd21618};

    typedef struct packed {
        logic [3:0]  lane;
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [63:0]      s_udphdr_tdata = '0;
    logic [15:0]      s_udphdr_tdest = '0;
    logic             s_udphdr_tvalid = 1'b0;
    logic             s_udphdr_tready;
    logic [63:0]      s_udpdata_tdata = '0;
    logic [7:0]       s_udpdata_tkeep = '0;
    logic             s_udpdata_tlast = 1'b0;
    logic             s_udpdata_tvalid = 1'b0;
    logic             s_udpdata_tready;
    logic [64*NP-1:0] m_hdr_tdata;
    logic [NP-1:0]    m_hdr_tvalid;
    logic [NP-1:0]    m_hdr_tready;
    logic [64*NP-1:0] m_data_tdata;
    logic [8*NP-1:0]  m_data_tkeep;
    logic [NP-1:0]    m_data_tlast;
    logic [NP-1:0]    m_data_tvalid;
    logic [NP-1:0]    m_data_tready;
    logic [31:0]      drop_count;

    // Second build with duplicate table entries.
    logic [63:0]      d2_hdr_tdata = '0;
    logic [15:0]      d2_hdr_tdest = '0;
    logic             d2_hdr_tvalid = 1'b0;
    logic             d2_hdr_tready;
    logic             d2_data_tready;
    logic [64*NP-1:0] d2_m_hdr_tdata;
    logic [NP-1:0]    d2_m_hdr_tvalid;
    logic [64*NP-1:0] d2_m_data_tdata;
    logic [8*NP-1:0]  d2_m_data_tkeep;
    logic [NP-1:0]    d2_m_data_tlast;
    logic [NP-1:0]    d2_m_data_tvalid;
    logic [31:0]      d2_drop_count;

    turf_udp_port_demux #(.NUM_PORTS(NP), .PORT_LIST(PLIST)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_udphdr_tdata(s_udphdr_tdata), .s_udphdr_tdest(s_udphdr_tdest),
        .s_udphdr_tvalid(s_udphdr_tvalid), .s_udphdr_tready(s_udphdr_tready),
        .s_udpdata_tdata(s_udpdata_tdata), .s_udpdata_tkeep(s_udpdata_tkeep),
        .s_udpdata_tlast(s_udpdata_tlast), .s_udpdata_tvalid(s_udpdata_tvalid),
        .s_udpdata_tready(s_udpdata_tready),
        .m_hdr_tdata(m_hdr_tdata), .m_hdr_tvalid(m_hdr_tvalid), .m_hdr_tready(m_hdr_tready),
        .m_data_tdata(m_data_tdata), .m_data_tkeep(m_data_tkeep), .m_data_tlast(m_data_tlast),
        .m_data_tvalid(m_data_tvalid), .m_data_tready(m_data_tready),
        .drop_count(drop_count)
    );

    turf_udp_port_demux #(.NUM_PORTS(NP), .PORT_LIST(PLIST_DUP)) dut_dup (
        .clk(clk), .rst_n(rst_n),
        .s_udphdr_tdata(d2_hdr_tdata), .s_udphdr_tdest(d2_hdr_tdest),
        .s_udphdr_tvalid(d2_hdr_tvalid), .s_udphdr_tready(d2_hdr_tready),
        .s_udpdata_tdata(64'd0), .s_udpdata_tkeep(8'd0),
        .s_udpdata_tlast(1'b0), .s_udpdata_tvalid(1'b0),
        .s_udpdata_tready(d2_data_tready),
        .m_hdr_tdata(d2_m_hdr_tdata), .m_hdr_tvalid(d2_m_hdr_tvalid), .m_hdr_tready(4'b0000),
        .m_data_tdata(d2_m_data_tdata), .m_data_tkeep(d2_m_data_tkeep),
        .m_data_tlast(d2_m_data_tlast), .m_data_tvalid(d2_m_data_tvalid),
        .m_data_tready(4'b1111),
        .drop_count(d2_drop_count)
    );

    int checks = 0;
    int passes = 0;

    // Reference model state, updated by the stimulus thread after each accepted edge.
    beat_t       exp_q[$];
    logic [63:0] pd[$];
    logic [7:0]  pk[$];
    logic        busy = 1'b0;
    logic        dropping = 1'b0;
    int          cur_lane = -1;
    logic [63:0] cur_hdr = '0;
    logic [31:0] exp_drops = '0;
    logic        mon_en = 1'b0;
    logic        gap_chk = 1'b0;
    int          gap_pct = 0;
    logic        rdy_mode = 1'b0;
    logic        hdr_hold = 1'b0;
    logic [NP-1:0] hdr_rdy_r = '1;
    logic [NP-1:0] data_rdy_r = '1;

    assign m_hdr_tready  = hdr_hold ? '0 : hdr_rdy_r;
    assign m_data_tready = data_rdy_r;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic timeout_abort(input string name);
        checks++;
        $display("FAIL %s: no handshake within %0d cycles", name, BOUND);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    endtask

    function automatic int lane_of(input logic [15:0] port);
        for (int i = 0; i < int'(NP); i++) begin
            if (PLIST[16*i +: 16] == port) return i;
        end
        return -1;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic rand_payload(input int n);
        pd.delete();
        pk.delete();
        for (int i = 0; i < n; i++) begin
            pd.push_back({$urandom, $urandom});
            pk.push_back((i == n - 1) ? 8'($urandom_range(1, 255)) : 8'hFF);
        end
    endtask

    // Sends header then payload from pd/pk; called at posedge+1, returns at posedge+1.
    task automatic send_dgram(input logic [15:0] port, input logic [63:0] hdr);
        int ln = lane_of(port);
        int n = pd.size();
        int t;
        cur_hdr = hdr;
        if (ln >= 0) begin
            for (int i = 0; i < n; i++)
                exp_q.push_back('{lane: 4'(ln), data: pd[i], keep: pk[i], last: (i == n - 1)});
        end
        s_udphdr_tdata  = hdr;
        s_udphdr_tdest  = port;
        s_udphdr_tvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!s_udphdr_tready) begin
            t++;
            if (t > int'(BOUND)) timeout_abort("hdr_accept");
            @(negedge clk);
        end
        @(posedge clk); #1;
        s_udphdr_tvalid = 1'b0;
        busy     = 1'b1;
        dropping = (ln < 0);
        cur_lane = ln;
        if (ln < 0) exp_drops = sat_inc(exp_drops);
        for (int i = 0; i < n; i++) begin
            while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                s_udpdata_tvalid = 1'b0;
                @(posedge clk); #1;
            end
            s_udpdata_tdata  = pd[i];
            s_udpdata_tkeep  = pk[i];
            s_udpdata_tlast  = (i == n - 1);
            s_udpdata_tvalid = 1'b1;
            t = 0;
            @(negedge clk);
            while (!s_udpdata_tready) begin
                t++;
                if (t > int'(BOUND)) timeout_abort("data_accept");
                @(negedge clk);
            end
            @(posedge clk); #1;
        end
        s_udpdata_tvalid = 1'b0;
        s_udpdata_tlast  = 1'b0;
        busy     = 1'b0;
        dropping = 1'b0;
        cur_lane = -1;
    endtask

    always @(posedge clk) begin
        #1;
        if (rdy_mode) begin
            hdr_rdy_r  = NP'($urandom);
            data_rdy_r = NP'($urandom);
        end else begin
            hdr_rdy_r  = '1;
            data_rdy_r = '1;
        end
    end

    // Compare process: expected readies/valids from the datagram phase, plus scoreboard.
    int   cyc = 0;
    int   last_end = -100;
    logic data_phase = 1'b0;
    always @(negedge clk) begin
        logic [NP-1:0] ehv;
        logic [NP-1:0] edv;
        logic          ehr;
        logic          edr;
        beat_t         b;
        cyc++;
        if (!rst_n) data_phase = 1'b0;
        if (mon_en && rst_n) begin
            ehv = '0;
            edv = '0;
            ehr = !busy;
            edr = 1'b0;
            if (busy && dropping) begin
                edr = 1'b1;
            end else if (busy && !data_phase) begin
                ehv[cur_lane] = 1'b1;
            end else if (busy) begin
                edv[cur_lane] = s_udpdata_tvalid;
                edr = m_data_tready[cur_lane];
            end
            chk("m_hdr_tvalid", 64'(m_hdr_tvalid), 64'(ehv));
            chk("m_data_tvalid", 64'(m_data_tvalid), 64'(edv));
            chk("s_udphdr_tready", 64'(s_udphdr_tready), 64'(ehr));
            chk("s_udpdata_tready", 64'(s_udpdata_tready), 64'(edr));
            chk("drop_count", 64'(drop_count), 64'(exp_drops));
            if (busy && !dropping && !data_phase)
                chk("m_hdr_tdata", m_hdr_tdata[64*cur_lane +: 64], cur_hdr);
            if ((m_hdr_tvalid & m_hdr_tready) != '0) begin
                data_phase = 1'b1;
                if (gap_chk) chk("frame_gap", 64'(cyc - last_end), 64'd2);
            end
            for (int l = 0; l < int'(NP); l++) begin
                if (m_data_tvalid[l] && m_data_tready[l]) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL extra_beat: lane %0d data %h, expected none", l, m_data_tdata[64*l +: 64]);
                    end else begin
                        b = exp_q.pop_front();
                        chk("beat_lane", 64'(l), 64'(b.lane));
                        chk("beat_data", m_data_tdata[64*l +: 64], b.data);
                        chk("beat_keep", 64'(m_data_tkeep[8*l +: 8]), 64'(b.keep));
                        chk("beat_last", 64'(m_data_tlast[l]), 64'(b.last));
                    end
                    if (m_data_tlast[l]) data_phase = 1'b0;
                end
            end
            if (s_udpdata_tvalid && s_udpdata_tready && s_udpdata_tlast) last_end = cyc;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic reset_checks(input string tag);
        chk({tag, "_hdr_tready"}, 64'(s_udphdr_tready), 64'd0);
        chk({tag, "_data_tready"}, 64'(s_udpdata_tready), 64'd0);
        chk({tag, "_hdr_tvalid"}, 64'(m_hdr_tvalid), 64'd0);
        chk({tag, "_data_tvalid"}, 64'(m_data_tvalid), 64'd0);
        chk({tag, "_drop_count"}, 64'(drop_count), 64'd0);
    endtask

    initial begin
        int t;
        int sel;
        logic [15:0] port;
        #12;
        reset_checks("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("hdr_tready_after_rst", 64'(s_udphdr_tready), 64'd1);
        @(posedge clk); #1;
        mon_en = 1'b1;

        // Match and stall: header held 3 cycles on lane 1.
        pd = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222};
        pk = '{8'hFF, 8'h0F};
        hdr_hold = 1'b1;
        fork
            send_dgram(16'd21603, 64'hC0A8_0102_1234_0018);
            begin
                t = 0;
                @(negedge clk);
                while (m_hdr_tvalid == '0) begin
                    t++;
                    if (t > int'(BOUND)) timeout_abort("hdr_valid");
                    @(negedge clk);
                end
                for (int k = 0; k < 3; k++) begin
                    if (k > 0) @(negedge clk);
                    chk("stall_hdr_tvalid", 64'(m_hdr_tvalid), 64'(4'b0010));
                    chk("stall_hdr_tdata", m_hdr_tdata[64 +: 64], 64'hC0A8_0102_1234_0018);
                end
                @(posedge clk); #1;
                hdr_hold = 1'b0;
            end
        join
        chk("match_drop_count", 64'(drop_count), 64'd0);

        // Drop: unknown port, three beats.
        rand_payload(3);
        send_dgram(16'd5000, 64'hDEAD_BEEF_0000_0020);
        @(negedge clk);
        chk("drop_count_one", 64'(drop_count), 64'd1);
        chk("drop_back_idle", 64'(s_udphdr_tready), 64'd1);
        @(posedge clk); #1;

        // Back-to-back mixed traffic.
        rand_payload(2);
        send_dgram(16'd21347, 64'h0A00_0001_1000_0010);
        gap_chk = 1'b1;
        rand_payload(3);
        send_dgram(16'd5000, 64'h0A00_0002_2000_0018);
        rand_payload(1);
        send_dgram(16'd21618, 64'h0A00_0003_3000_0008);
        rand_payload(4);
        send_dgram(16'd21347, 64'h0A00_0004_4000_0020);
        gap_chk = 1'b0;
        @(negedge clk);
        chk("mixed_drop_count", 64'(drop_count), 64'd2);
        chk("mixed_queue_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;

        // Random traffic with backpressure and source gaps.
        rdy_mode = 1'b1;
        gap_pct = 30;
        for (int d = 0; d < 1000; d++) begin
            sel = int'($urandom_range(0, 5));
            if (sel < int'(NP)) port = PLIST[16*sel +: 16];
            else if (sel == int'(NP)) port = 16'($urandom);
            else port = 16'd5000;
            rand_payload(int'($urandom_range(1, 5)));
            send_dgram(port, {$urandom, $urandom});
        end
        rdy_mode = 1'b0;
        gap_pct = 0;
        @(posedge clk); #1;
        chk("random_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reset during beat 2 of 4, then a clean datagram to lane 2.
        mon_en = 1'b0;
        rand_payload(4);
        s_udphdr_tdata = 64'h0101_0101_5555_0028;
        s_udphdr_tdest = 16'd21347;
        s_udphdr_tvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!s_udphdr_tready) begin
            t++;
            if (t > int'(BOUND)) timeout_abort("rst_hdr_accept");
            @(negedge clk);
        end
        @(posedge clk); #1;
        s_udphdr_tvalid = 1'b0;
        s_udpdata_tdata = pd[0];
        s_udpdata_tkeep = pk[0];
        s_udpdata_tvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!s_udpdata_tready) begin
            t++;
            if (t > int'(BOUND)) timeout_abort("rst_beat1");
            @(negedge clk);
        end
        @(posedge clk); #1;
        s_udpdata_tdata = pd[1];
        s_udpdata_tkeep = pk[1];
        @(negedge clk);
        chk("rst_pre_data_tvalid", 64'(m_data_tvalid), 64'(4'b1000));
        rst_n = 1'b0;
        #1;
        reset_checks("midrst");
        s_udpdata_tvalid = 1'b0;
        @(negedge clk);
        reset_checks("midrst2");
        rst_n = 1'b1;
        exp_q.delete();
        busy = 1'b0;
        dropping = 1'b0;
        cur_lane = -1;
        exp_drops = '0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("hdr_tready_after_midrst", 64'(s_udphdr_tready), 64'd1);
        @(posedge clk); #1;
        mon_en = 1'b1;
        rand_payload(3);
        send_dgram(16'd21600, 64'h0202_0202_6666_0020);
        @(negedge clk);
        chk("post_rst_queue_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;

        // Duplicate table entries: 21600 lands on the lower index.
        d2_hdr_tdata = 64'h0303_0303_7777_0010;
        d2_hdr_tdest = 16'd21600;
        d2_hdr_tvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!d2_hdr_tready) begin
            t++;
            if (t > int'(BOUND)) timeout_abort("dup_hdr_accept");
            @(negedge clk);
        end
        @(posedge clk); #1;
        d2_hdr_tvalid = 1'b0;
        @(negedge clk);
        chk("dup_hdr_tvalid", 64'(d2_m_hdr_tvalid), 64'(4'b0010));
        chk("dup_hdr_tdata", d2_m_hdr_tdata[64 +: 64], 64'h0303_0303_7777_0010);
        @(posedge clk); #1;

        // Saturation of the drop counter.
        force dut.drop_q = 32'hFFFF_FFFE;
        exp_drops = 32'hFFFF_FFFE;
        #1;
        release dut.drop_q;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            rand_payload(d + 1);
            send_dgram(16'd4000 + 16'(d), {$urandom, $urandom});
        end
        @(negedge clk);
        chk("drop_saturated", 64'(drop_count), 64'h0000_0000_FFFF_FFFF);
        @(posedge clk); #1;

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/turf_udp_port_demux.md
# turf_udp_port_demux

Receive-side UDP dispatcher sitting directly downstream of the TURF UDP core. It accepts each received datagram's header beat and its payload stream, matches the header's destination port against a parameterised table, and steers the header and the complete payload to one of `NUM_PORTS` service outputs. Datagrams addressed to unknown ports are drained and counted, so one bad packet never stalls the receive path.

## Interface
Parameters:
- `NUM_PORTS`, 4: number of service outputs, 1–8.
- `PORT_LIST`, {16'd21618, 16'd21603, 16'd21600, 16'd21347}: `NUM_PORTS`×16 packed UDP port numbers; entry i is `PORT_LIST[16*i +: 16]`.

Ports:
- `clk` in 1: the only clock; all logic is synchronous to it.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_udphdr_tdata` in 64: received header; [32 +: 32] source IP, [16 +: 16] source port, [0 +: 16] UDP length.
- `s_udphdr_tdest` in 16: destination port.
- `s_udphdr_tvalid` / `s_udphdr_tready`: in 1 / out 1.
- `s_udpdata_tdata` in 64, `s_udpdata_tkeep` in 8, `s_udpdata_tlast` in 1: received payload.
- `s_udpdata_tvalid` / `s_udpdata_tready`: in 1 / out 1.
- `m_hdr_tdata` out 64×`NUM_PORTS`: per-output header, copied unchanged from `s_udphdr_tdata`.
- `m_hdr_tvalid` out `NUM_PORTS`; `m_hdr_tready` in `NUM_PORTS`.
- `m_data_tdata` out 64×`NUM_PORTS`, `m_data_tkeep` out 8×`NUM_PORTS`, `m_data_tlast` out `NUM_PORTS`.
- `m_data_tvalid` out `NUM_PORTS`; `m_data_tready` in `NUM_PORTS`.
- `drop_count` out 32: number of datagrams dropped; saturates at 0xFFFFFFFF.

## Operation
- The upstream core guarantees one header per datagram. Every datagram has at least one payload beat, and its last beat carries `tlast`.
- The FSM has four states: IDLE, HDR, DATA, DROP.
- IDLE:
  - `s_udphdr_tready`=1 and `s_udpdata_tready`=0.
  - On a header handshake, register `tdata` and compare `tdest` against every `PORT_LIST` entry in parallel.
  - If any entry matches, latch the lowest matching index i as `sel` and go to HDR.
  - If no entry matches, go to DROP and increment `drop_count` (saturating) on the same edge.
- HDR:
  - `m_hdr_tvalid[sel]`=1 and `m_hdr_tdata[sel]` holds the registered header. Both input readies are 0.
  - On `m_hdr_tready[sel]`, go to DATA.
- DATA, a combinational pass-through to output `sel` only:
  - `m_data_tvalid[sel]`=`s_udpdata_tvalid`, `s_udpdata_tready`=`m_data_tready[sel]`.
  - `tdata`, `tkeep` and `tlast` are routed straight through.
  - On a handshake with `tlast`=1, go to IDLE.
- DROP:
  - `s_udpdata_tready`=1. All `m_*_tvalid`=0.
  - On a handshake with `tlast`=1, go to IDLE.
- Output lanes other than `sel` always have `tvalid`=0. Their `tdata`, `tkeep` and `tlast` values are don't-care.
- Duplicate `PORT_LIST` entries are legal; the lowest index wins.

## Timing
- Reset values:
  - State IDLE; `sel`=0; `drop_count`=0.
  - All `m_hdr_tvalid` and `m_data_tvalid` are 0.
  - `s_udpdata_tready`=0. `s_udphdr_tready` is 0 while `rst_n` is low, and 1 from the first cycle after release.
- Header latency: `m_hdr_tvalid[sel]` rises on the cycle after the input header handshake. It is held stable with constant data until `m_hdr_tready` is seen.
- Payload latency: 0 cycles (combinational). The first payload beat can transfer on the cycle after the output header handshake.
- Throughput: one datagram's overhead is 2 idle cycles between frames (IDLE accept, plus HDR). Payload runs at one beat per cycle when unstalled.
- A header is never accepted while a payload is in flight (HDR, DATA or DROP), so the next datagram is held off by upstream backpressure.
- `tlast` on the same cycle as `tvalid` but without `tready`: no transition occurs.
- A one-beat datagram (first beat has `tlast`) returns to IDLE after that single beat.
- `drop_count` increments exactly once per dropped header, including when the drop happens back-to-back with another.
- Reset asserted mid-frame: everything clears to the reset values immediately, and the partial output frame is abandoned without `tlast`. Downstream consumers share `rst_n`.

## Test plan
- **Match and stall:**
  - Stimulus: header `tdest`=21603, `tdata`=0xC0A8_0102_1234_0018, followed by a 2-beat payload (0x1111…, then 0x2222… with `tkeep`=0x0F and `tlast`). Hold `m_hdr_tready[1]`=0 for 3 cycles.
  - Required: `m_hdr_tvalid[1]` is held stable with unchanged data; the payload then emerges intact only on lane 1; `drop_count`=0.
- **Drop:**
  - Stimulus: header `tdest`=5000 with a 3-beat payload.
  - Required: `s_udpdata_tready`=1 throughout; no `m_*_tvalid` is asserted; `drop_count`=1; the state is IDLE after `tlast`.
- **Back-to-back mixed traffic:**
  - Stimulus: datagrams to 21347, 5000, 21618 and 21347, with all outputs ready.
  - Required: lanes 3, (drop), 0, 3 in that order; each payload is bit-exact; `drop_count`=1; 2 cycles between frames.
- **Random backpressure:**
  - Stimulus: 1000 random datagrams with random `m_data_tready` and `s_udpdata_tvalid` gaps.
  - Required: the scoreboard shows zero lost, duplicated or misrouted beats.
- **Reset mid-payload:**
  - Stimulus: pull `rst_n` low for 1 cycle during the DATA beat 2 of 4, then send a new datagram to 21600.
  - Required: all outputs are at reset values during reset; the new datagram is delivered cleanly on lane 2.
- **Saturation and duplicates:**
  - Stimulus: force `drop_count` to 0xFFFFFFFE and drop 3 datagrams. Separately, build with `PORT_LIST` entries 1 and 2 both set to 21600.
  - Required: `drop_count` stops at 0xFFFFFFFF; a datagram to 21600 goes to lane 1.
